// File: rtl/el2_dec_trigger_seq_pkg.sv
// Shared encodings and types for the decode-stage PC/opcode trigger sequencer.
package el2_dec_trigger_seq_pkg;

    localparam logic [1:0] TRIG_MODE_MASK = 2'b00;
    localparam logic [1:0] TRIG_MODE_GE   = 2'b01;
    localparam logic [1:0] TRIG_MODE_LT   = 2'b10;
    localparam logic [1:0] TRIG_MODE_OFF  = 2'b11;

    typedef enum logic {
        PAIR_IDLE  = 1'b0,
        PAIR_ARMED = 1'b1
    } pair_state_t;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } el2_trigger_pkt_t;

endpackage

// File: rtl/el2_dec_trigger_cmp.sv
// Single-trigger compare: NAPOT mask/exact match, unsigned >= and unsigned <.
module el2_dec_trigger_cmp
    import el2_dec_trigger_seq_pkg::*;
(
    input  logic [31:0] data,
    input  logic [31:0] tdata2,
    input  logic        masken,
    input  logic [1:0]  mode,
    output logic        hit
);

    logic        mask_on;
    logic        low_ones;
    logic [31:0] match_vec;

    // An all-ones tdata2 degenerates to an exact compare rather than match-all.
    assign mask_on = masken & ~(&tdata2);

    // Each bit is a don't-care when every lower tdata2 bit is one.
    always_comb begin
        match_vec = '0;
        low_ones  = mask_on;
        for (int b = 0; b < 32; b++) begin
            match_vec[b] = low_ones | (tdata2[b] == data[b]);
            low_ones     = low_ones & tdata2[b];
        end
    end

    always_comb begin
        case (mode)
            TRIG_MODE_MASK: hit = &match_vec;
            TRIG_MODE_GE:   hit = (data >= tdata2);
            TRIG_MODE_LT:   hit = (data < tdata2);
            default:        hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/el2_dec_trigger_seq.sv
// Decode-stage trigger unit: per-trigger compare, match-count threshold and
// optional even/odd pair chaining within an instruction window.
module el2_dec_trigger_seq
    import el2_dec_trigger_seq_pkg::*;
#(
    parameter int NTRIG = 4,
    parameter int CNTW  = 8,
    parameter int WINW  = 8
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  el2_trigger_pkt_t [NTRIG-1:0]   trigger_pkt_any,
    input  logic [NTRIG-1:0][1:0]          trig_mode,
    input  logic [NTRIG-1:0]               trig_chain,
    input  logic [NTRIG-1:0][CNTW-1:0]     trig_count,
    input  logic [WINW-1:0]                trig_window,
    input  logic [NTRIG-1:0]               trig_cfg_wr,
    input  logic [31:1]                    dec_i0_pc_d,
    input  logic [31:0]                    dec_i0_instr_d,
    input  logic                           dec_i0_valid_d,
    input  logic                           dec_i0_decode_d,
    input  logic                           dec_tlu_flush_lower_r,
    output logic [NTRIG-1:0]               dec_i0_trigger_match_d,
    output logic [NTRIG-1:0]               trig_hit_sticky,
    output logic [NTRIG/2-1:0]             trig_armed
);

    localparam int NPAIR = NTRIG / 2;

    logic             upd;
    logic [NTRIG-1:0] raw;
    logic [NTRIG-1:0] qual;
    logic [NPAIR-1:0] fire_lo;
    logic [NPAIR-1:0] fire_hi;
    logic             unused_chain;

    assign upd          = dec_i0_decode_d & ~dec_tlu_flush_lower_r;
    assign unused_chain = ^trig_chain;

    for (genvar i = 0; i < NTRIG; i++) begin : g_trig
        logic [31:0]     data;
        logic            hit;
        logic [CNTW:0]   cnt_inc;
        logic [CNTW-1:0] cnt;
        logic            sticky;

        assign data = trigger_pkt_any[i].select ? dec_i0_instr_d
                                                : {dec_i0_pc_d, trigger_pkt_any[i].tdata2[0]};

        el2_dec_trigger_cmp u_cmp (
            .data   (data),
            .tdata2 (trigger_pkt_any[i].tdata2),
            .masken (trigger_pkt_any[i].match),
            .mode   (trig_mode[i]),
            .hit    (hit)
        );

        assign raw[i]  = trigger_pkt_any[i].execute & trigger_pkt_any[i].m & dec_i0_valid_d & hit;
        // One extra bit keeps the threshold compare exact at the counter's top value.
        assign cnt_inc = {1'b0, cnt} + {{CNTW{1'b0}}, 1'b1};
        assign qual[i] = raw[i] & (cnt_inc >= {1'b0, trig_count[i]});

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l)                cnt <= '0;
            else if (trig_cfg_wr[i])   cnt <= '0;
            else if (upd & qual[i])    cnt <= '0;
            else if (upd & raw[i])     cnt <= cnt_inc[CNTW-1:0];
        end

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l)                                  sticky <= 1'b0;
            else if (trig_cfg_wr[i])                     sticky <= 1'b0;
            else if (upd & dec_i0_trigger_match_d[i])    sticky <= 1'b1;
        end

        assign trig_hit_sticky[i] = sticky;
    end

    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
        pair_state_t     state;
        logic [WINW-1:0] win;
        logic            clear;

        assign clear      = ~trig_chain[2*k] | dec_tlu_flush_lower_r
                          | trig_cfg_wr[2*k] | trig_cfg_wr[2*k+1];
        assign fire_lo[k] = qual[2*k] & qual[2*k+1];
        assign fire_hi[k] = qual[2*k+1] & ((state == PAIR_ARMED) | qual[2*k]);

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                state <= PAIR_IDLE;
                win   <= '0;
            end else if (clear) begin
                state <= PAIR_IDLE;
            end else if (upd) begin
                case (state)
                    PAIR_IDLE: begin
                        if (qual[2*k] & ~qual[2*k+1]) begin
                            state <= PAIR_ARMED;
                            win   <= trig_window;
                        end
                    end
                    PAIR_ARMED: begin
                        if (qual[2*k+1])             state <= PAIR_IDLE;
                        else if (qual[2*k])          win   <= trig_window;
                        // A window of 0 or 1 lapses on the first non-firing instruction.
                        else if (win <= WINW'(1))    state <= PAIR_IDLE;
                        else                         win   <= win - WINW'(1);
                    end
                    default: state <= PAIR_IDLE;
                endcase
            end
        end

        assign trig_armed[k] = (state == PAIR_ARMED);
    end

    always_comb begin
        dec_i0_trigger_match_d = qual;
        for (int k = 0; k < NPAIR; k++) begin
            if (trig_chain[2*k]) begin
                dec_i0_trigger_match_d[2*k]   = fire_lo[k];
                dec_i0_trigger_match_d[2*k+1] = fire_hi[k];
            end
        end
    end

endmodule

// File: tb/tb_el2_dec_trigger_seq.sv
// Table-driven scoreboard bench for el2_dec_trigger_seq with NTRIG=4.
module tb_el2_dec_trigger_seq;
    import el2_dec_trigger_seq_pkg::*;

    typedef struct {
        logic [30:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        dec;
        logic        flush;
        logic [3:0]  cfg;
        logic [3:0]  em;
        logic [3:0]  es;
        logic [1:0]  ea;
    } vec_t;

    logic                   clk;
    logic                   rst_l;
    el2_trigger_pkt_t [3:0] pkt;
    logic [3:0][1:0]        mode;
    logic [3:0]             chain;
    logic [3:0][7:0]        count;
    logic [7:0]             window;
    logic [3:0]             cfg_wr;
    logic [31:1]            pc;
    logic [31:0]            instr;
    logic                   valid;
    logic                   decode;
    logic                   flush;
    logic [3:0]             match_d;
    logic [3:0]             sticky;
    logic [1:0]             armed;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";
    vec_t  sb[$];
    vec_t  tbl[$];
    vec_t  prev;
    bit    have_prev = 0;

    localparam logic [30:0] PA  = 31'h4000_0080;
    localparam logic [30:0] PAX = 31'h4000_0081;
    localparam logic [30:0] PB  = 31'h4000_0100;
    localparam logic [30:0] PC  = 31'h4000_0200;
    localparam logic [30:0] PG  = 31'h4000_0000;
    localparam logic [30:0] H1  = 31'h1000_0000;
    localparam logic [30:0] H2  = 31'h7FFF_FFFF;
    localparam logic [30:0] LO  = 31'h0800_0000;

    el2_dec_trigger_seq dut (
        .clk                    (clk),
        .rst_l                  (rst_l),
        .trigger_pkt_any        (pkt),
        .trig_mode              (mode),
        .trig_chain             (chain),
        .trig_count             (count),
        .trig_window            (window),
        .trig_cfg_wr            (cfg_wr),
        .dec_i0_pc_d            (pc),
        .dec_i0_instr_d         (instr),
        .dec_i0_valid_d         (valid),
        .dec_i0_decode_d        (decode),
        .dec_tlu_flush_lower_r  (flush),
        .dec_i0_trigger_match_d (match_d),
        .trig_hit_sticky        (sticky),
        .trig_armed             (armed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [30:0] p, input logic [31:0] ins, input logic v,
                                input logic d, input logic f, input logic [3:0] c,
                                input logic [3:0] em, input logic [3:0] es, input logic [1:0] ea);
        vec_t r;
        r.pc = p; r.instr = ins; r.valid = v; r.dec = d; r.flush = f; r.cfg = c;
        r.em = em; r.es = es; r.ea = ea;
        return r;
    endfunction

    task automatic set_trig(input int i, input logic sel, input logic mt, input logic [31:0] td,
                            input logic [1:0] md, input logic [7:0] cn);
        pkt[i].select  = sel;
        pkt[i].match   = mt;
        pkt[i].execute = 1'b1;
        pkt[i].m       = 1'b1;
        pkt[i].tdata2  = td;
        mode[i]        = md;
        count[i]       = cn;
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        pc = v.pc; instr = v.instr; valid = v.valid; decode = v.dec;
        flush = v.flush; cfg_wr = v.cfg;
        sb.push_back(v);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        valid = 1'b0; decode = 1'b0; flush = 1'b0; cfg_wr = '0;
        @(negedge clk);
    endtask

    task automatic run_table();
        foreach (tbl[j]) apply(tbl[j]);
        drain();
        tbl.delete();
    endtask

    // Combinational fire bits checked mid-cycle; registered status one cycle later.
    always @(negedge clk) begin
        if (have_prev) begin
            check("sticky", {28'd0, sticky}, {28'd0, prev.es});
            check("armed",  {30'd0, armed},  {30'd0, prev.ea});
            have_prev = 0;
        end
        if (sb.size() > 0) begin
            prev = sb.pop_front();
            check("match", {28'd0, match_d}, {28'd0, prev.em});
            have_prev = 1;
        end
    end

    initial begin
        rst_l = 1'b0; chain = '0; window = 8'd0; cfg_wr = '0;
        pc = '0; instr = '0; valid = 1'b0; decode = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) set_trig(i, 1'b0, 1'b0, 32'd0, TRIG_MODE_OFF, 8'd1);
        #12;
        check("rst_sticky", {28'd0, sticky}, 32'd0);
        check("rst_armed",  {30'd0, armed},  32'd0);
        check("rst_match",  {28'd0, match_d}, 32'd0);
        @(negedge clk); rst_l = 1'b1;

        phase = "A_mask";
        set_trig(0, 1'b0, 1'b0, 32'h8000_0100, TRIG_MODE_MASK, 8'd1);
        set_trig(2, 1'b1, 1'b1, 32'h1234_50FF, TRIG_MODE_MASK, 8'd1);
        tbl.push_back(mk(PA,  32'h0,          1, 1, 0, 4'b0000, 4'b0001, 4'b0001, 2'b00));
        tbl.push_back(mk(PAX, 32'h0,          1, 1, 0, 4'b0000, 4'b0000, 4'b0001, 2'b00));
        tbl.push_back(mk(PA,  32'h0,          0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 2'b00));
        tbl.push_back(mk(PAX, 32'h1234_5100,  1, 1, 0, 4'b0000, 4'b0100, 4'b0101, 2'b00));
        tbl.push_back(mk(PAX, 32'h1234_5300,  1, 1, 0, 4'b0000, 4'b0000, 4'b0101, 2'b00));
        tbl.push_back(mk(PA,  32'h1234_51FF,  1, 0, 0, 4'b0000, 4'b0101, 4'b0101, 2'b00));
        tbl.push_back(mk(PAX, 32'h0,          1, 1, 0, 4'b0001, 4'b0000, 4'b0100, 2'b00));
        tbl.push_back(mk(PA,  32'h0,          1, 0, 0, 4'b0000, 4'b0001, 4'b0100, 2'b00));
        tbl.push_back(mk(PA,  32'h0,          1, 1, 1, 4'b0000, 4'b0001, 4'b0100, 2'b00));
        tbl.push_back(mk(PA,  32'h0,          1, 1, 0, 4'b0000, 4'b0001, 4'b0101, 2'b00));
        run_table();

        phase = "B_count";
        set_trig(0, 1'b0, 1'b0, 32'h0,         TRIG_MODE_OFF, 8'd1);
        set_trig(1, 1'b0, 1'b0, 32'h2000_0000, TRIG_MODE_GE,  8'd3);
        set_trig(2, 1'b0, 1'b0, 32'h0,         TRIG_MODE_OFF, 8'd1);
        set_trig(3, 1'b0, 1'b0, 32'h2000_0000, TRIG_MODE_LT,  8'd0);
        tbl.push_back(mk(PG, 32'h0, 0, 1, 0, 4'b1111, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(LO, 32'h0, 1, 1, 0, 4'b0000, 4'b1000, 4'b1000, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b1000, 2'b00));
        tbl.push_back(mk(H2, 32'h0, 1, 1, 0, 4'b0000, 4'b0010, 4'b1010, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b1010, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 1, 1, 4'b0000, 4'b0000, 4'b1010, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1010, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b1010, 2'b00));
        tbl.push_back(mk(H1, 32'h0, 1, 1, 0, 4'b0000, 4'b0010, 4'b1010, 2'b00));
        run_table();

        phase = "C_chain";
        set_trig(0, 1'b0, 1'b0, 32'h8000_0100, TRIG_MODE_MASK, 8'd1);
        set_trig(1, 1'b0, 1'b0, 32'h8000_0200, TRIG_MODE_MASK, 8'd1);
        set_trig(3, 1'b0, 1'b0, 32'h0,         TRIG_MODE_OFF,  8'd1);
        chain = 4'b0001; window = 8'd2;
        tbl.push_back(mk(PG, 32'h0, 0, 1, 0, 4'b1111, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(PA, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b01));
        tbl.push_back(mk(PG, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b01));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0010, 4'b0010, 2'b00));
        tbl.push_back(mk(PA, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b01));
        tbl.push_back(mk(PG, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b01));
        tbl.push_back(mk(PG, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b00));
        tbl.push_back(mk(PG, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b00));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b00));
        tbl.push_back(mk(PA, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b01));
        tbl.push_back(mk(PG, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b01));
        tbl.push_back(mk(PA, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b01));
        tbl.push_back(mk(PG, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 2'b01));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0010, 4'b0010, 2'b00));
        tbl.push_back(mk(PG, 32'h0, 0, 1, 0, 4'b0011, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(PA, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b01));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 1, 4'b0000, 4'b0010, 4'b0000, 2'b00));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00));
        run_table();

        phase = "E_simul";
        set_trig(0, 1'b0, 1'b0, 32'h0,         TRIG_MODE_OFF,  8'd1);
        set_trig(1, 1'b0, 1'b0, 32'h0,         TRIG_MODE_OFF,  8'd1);
        set_trig(2, 1'b0, 1'b0, 32'h8000_0400, TRIG_MODE_MASK, 8'd1);
        set_trig(3, 1'b0, 1'b0, 32'h8000_0000, TRIG_MODE_GE,   8'd1);
        chain = 4'b0100;
        tbl.push_back(mk(PG,           32'h0, 0, 1, 0, 4'b1111, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(PC,           32'h0, 1, 1, 0, 4'b0000, 4'b1100, 4'b1100, 2'b00));
        tbl.push_back(mk(31'h4000_0300, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b1100, 2'b00));
        tbl.push_back(mk(PC,           32'h0, 1, 0, 0, 4'b0000, 4'b1100, 4'b1100, 2'b00));
        run_table();

        phase = "F_reset";
        set_trig(0, 1'b0, 1'b0, 32'h8000_0100, TRIG_MODE_MASK, 8'd1);
        set_trig(1, 1'b0, 1'b0, 32'h8000_0200, TRIG_MODE_MASK, 8'd3);
        set_trig(2, 1'b0, 1'b0, 32'h8000_0400, TRIG_MODE_MASK, 8'd1);
        set_trig(3, 1'b0, 1'b0, 32'h0,         TRIG_MODE_OFF,  8'd1);
        chain = 4'b0001; window = 8'd8;
        tbl.push_back(mk(PG, 32'h0, 0, 1, 0, 4'b1111, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(PA, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b01));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b01));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b01));
        tbl.push_back(mk(PC, 32'h0, 1, 1, 0, 4'b0000, 4'b0100, 4'b0100, 2'b01));
        run_table();

        #1 rst_l = 1'b0;
        #1;
        check("async_sticky", {28'd0, sticky}, 32'd0);
        check("async_armed",  {30'd0, armed},  32'd0);
        check("async_match",  {28'd0, match_d}, 32'd0);
        @(negedge clk); #1 rst_l = 1'b1;

        phase = "F_after";
        chain = 4'b0000;
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0010, 4'b0010, 2'b00));
        run_table();

        phase = "F_cfgwr";
        count[1] = 8'd1;
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0010, 4'b0010, 4'b0000, 2'b00));
        tbl.push_back(mk(PB, 32'h0, 1, 1, 0, 4'b0000, 4'b0010, 4'b0010, 2'b00));
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/el2_dec_trigger_seq.md
Name: el2_dec_trigger_seq

Overview:
Parametrised decode-stage PC/opcode trigger unit with NTRIG triggers. Each trigger has a compare mode (masked/exact, >=, <), a match-count threshold, and optional sequential chaining of even/odd pairs within an instruction window. It sits in DEC beside the TLU trigger CSRs. It drives per-trigger fire bits for the i0 instruction in decode, plus sticky hit status for the TLU.

Parameters:
NTRIG, 4, number of triggers; pairs are (2k, 2k+1); an odd last trigger is never chained.
CNTW, 8, width of per-trigger match-count threshold and counter.
WINW, 8, width of sequential-chain window counter.

Ports:
clk  in  1  core clock
rst_l  in  1  reset; asynchronous, active-low
trigger_pkt_any  in  el2_trigger_pkt_t[NTRIG]  select, match, execute, m, tdata2 per trigger
trig_mode  in  [NTRIG][1:0]  00 mask/exact (match bit selects masking), 01 data>=tdata2, 10 data<tdata2, 11 never
trig_chain  in  [NTRIG]  bit 2k set: pair k runs in sequence mode
trig_count  in  [NTRIG][CNTW]  matches required per fire
trig_window  in  WINW  instructions allowed between arm and fire
trig_cfg_wr  in  [NTRIG]  config write pulse; clears that trigger's state
dec_i0_pc_d  in  31  i0 PC [31:1]
dec_i0_instr_d  in  32  i0 opcode
dec_i0_valid_d  in  1  i0 valid in decode
dec_i0_decode_d  in  1  i0 leaves decode this cycle (state update strobe)
dec_tlu_flush_lower_r  in  1  pipeline flush
dec_i0_trigger_match_d  out  [NTRIG]  fire bits for current i0 (combinational)
trig_hit_sticky  out  [NTRIG]  registered sticky hit per trigger
trig_armed  out  [NTRIG/2]  registered pair-armed status

Behaviour:
- Reset values: trig_hit_sticky=0, trig_armed=0, all counters=0, dec_i0_trigger_match_d=0.
- Compare data: {pc[31:1],tdata2[0]} when select=0; instr when select=1.
- raw[i] = execute & m & valid & mode compare.
  - Mode 00 uses rvmaskandmatch semantics.
  - Modes 01/10 are unsigned 32-bit compares.
- Count stage: qual[i] = raw[i] & (cnt[i]+1 >= trig_count[i]).
  - trig_count of 0 or 1 means fire on every raw match.
- Count update, only when dec_i0_decode_d & ~flush:
  - raw & ~qual: cnt++.
  - qual: cnt<=0.
  - The counter never exceeds trig_count-1, so no wrap.
- Unchained trigger: match_d[i] = qual[i].
- Pair FSM per k when trig_chain[2k]: states IDLE, ARMED(win).
  - IDLE, qual[2k] & ~qual[2k+1] on decode: go to ARMED, win<=trig_window.
  - IDLE, qual[2k] & qual[2k+1] on the same instruction: fire both bits, stay IDLE.
  - ARMED, qual[2k+1]: match_d[2k+1]=1, return to IDLE on decode.
  - ARMED, qual[2k] only: re-arm, win reloaded.
  - ARMED, decode with no fire: win--. When win reaches 0 the FSM returns to IDLE; window 0 therefore expires after one instruction.
  - While chained, match_d[2k] is asserted only in the simultaneous case; a lone arm never fires bit 2k.
- Flush: every pair goes to IDLE. Counter and FSM updates for the current instruction are suppressed. Counters keep their values. match_d is still driven combinationally; the TLU ignores it.
- trig_cfg_wr[i]: clears cnt[i] and sticky[i]. If i belongs to a chained pair, that pair goes to IDLE. This has priority over the same-cycle update.
- Sticky: set when match_d[i] & dec_i0_decode_d & ~flush; cleared only by cfg_wr or reset.
- No update when ~dec_i0_decode_d (decode stall); outputs stay stable on the held instruction.
- Reset mid-sequence: asynchronous clear of all state, independent of clk.

Decomposition:
- el2_pkg: trigger-mode encoding constants (TRIG_MODE_MASK/GE/LT/OFF) and a per-pair state typedef (IDLE/ARMED).
- Sub-module el2_dec_trigger_cmp: one trigger's mode compare (wraps rvmaskandmatch plus GE/LT compares).
- Pair FSMs and counters live in a generate loop in the top.

Test Plan:
1. Mode 00, match=0, select=0, tdata2=0x8000_0100, count=1, pc=0x4000_0080 (byte 0x8000_0100) -> match_d[0]=1 and sticky[0] set after decode; pc=0x4000_0081 -> 0.
2. Trigger 1, mode 01, tdata2=0x2000_0000, count=3: three decodes with PC≥0x2000_0000 -> match_d[1] only on the 3rd, counter back to 0; the 4th match does not fire.
3. Pair 0 chained, window=2: PC hits T0, then one non-matching instr, then T1 hit -> match_d[1]=1 and match_d[0] never asserted. Repeat with three gap instrs -> no fire, trig_armed[0] cleared.
4. Armed pair 0 plus dec_tlu_flush_lower_r pulse -> trig_armed[0]=0 next cycle, counters unchanged; a later T1 hit alone -> no fire.
5. Same instruction matches T2 and T3 with chain[2]=1 -> match_d[3:2]=2'b11 and both sticky bits set.
6. rst_l asserted while armed, with cnt[1]=2 and sticky set -> all status 0 immediately (before the next clk edge); trig_cfg_wr[1] on the same cycle as a T1 qual -> sticky[1] stays 0.
